// File: rtl/ls_pkg.sv
// Shared definitions for the load/store queue unit: opcodes, access-size
// codes, FSM encoding, queue entry layout and small opcode decode helpers.
// Queue entry field widths follow the LS_* localparams below; the unit's
// default parameters match them.
package ls_pkg;

  localparam int LS_DATA_W = 32;
  localparam int LS_ADDR_W = 32;
  localparam int LS_TAG_W  = 4;
  localparam int LS_NAME_W = 5;
  localparam int LS_OP_W   = 6;

  localparam logic [LS_OP_W-1:0] OP_LB  = 6'h00;
  localparam logic [LS_OP_W-1:0] OP_LH  = 6'h01;
  localparam logic [LS_OP_W-1:0] OP_LW  = 6'h02;
  localparam logic [LS_OP_W-1:0] OP_LBU = 6'h04;
  localparam logic [LS_OP_W-1:0] OP_LHU = 6'h05;
  localparam logic [LS_OP_W-1:0] OP_SB  = 6'h08;
  localparam logic [LS_OP_W-1:0] OP_SH  = 6'h09;
  localparam logic [LS_OP_W-1:0] OP_SW  = 6'h0a;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } ls_state_t;

  typedef struct packed {
    logic [LS_OP_W-1:0]   op;
    logic [LS_ADDR_W-1:0] addr;
    logic [LS_DATA_W-1:0] wdata;
    logic [LS_TAG_W-1:0]  tag;
    logic [LS_NAME_W-1:0] name;
  } ls_entry_t;

  // Unknown opcodes fall into the word bucket.
  function automatic logic [1:0] op_len(input logic [LS_OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return LEN_B;
      OP_LH, OP_LHU, OP_SH: return LEN_H;
      default:              return LEN_W;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [LS_OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [LS_OP_W-1:0] op,
                                         input logic [1:0] a);
    logic [1:0] len;
    len = op_len(op);
    return ((len == LEN_H) && a[0]) || ((len == LEN_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/ls_req_fifo.sv
// In-order request queue: DEPTH-entry synchronous FIFO with flush.
// The head entry is visible combinationally on dout; flush wins over
// push and pop in the same cycle.
module ls_req_fifo
  import ls_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  ls_entry_t    din,
  output ls_entry_t    dout,
  output logic [PW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  ls_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~flush & ~full;
  assign pop_ok  = pop & ~flush & ~empty;
  assign dout    = mem[rd_ptr];

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/ls_queue_unit.sv
// Load/store execution unit: queues requests from the LS buffer, issues
// them one at a time to the memory controller and reports completions to
// the ROB. Optional feature macro: LS_MISALIGN_TRAP_EN (trap misaligned
// half/word accesses instead of issuing them).
//
//  state    | meaning
//  ST_IDLE  | no transaction outstanding; issue head when memory is free
//  ST_WAIT  | transaction outstanding; mem_* held until mem_done
//  ST_DRAIN | flushed while outstanding; swallow the mem_done
module ls_queue_unit
  import ls_pkg::*;
#(
  parameter int DATA_W = LS_DATA_W,
  parameter int ADDR_W = LS_ADDR_W,
  parameter int TAG_W  = LS_TAG_W,
  parameter int NAME_W = LS_NAME_W,
  parameter int OP_W   = LS_OP_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_base,
  input  logic [DATA_W-1:0] req_src,
  input  logic [DATA_W-1:0] req_imm,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [NAME_W-1:0] req_name,
  input  logic              mem_free,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_len,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rob_valid,
  output logic [DATA_W-1:0] rob_data,
  output logic [TAG_W-1:0]  rob_tag,
  output logic [NAME_W-1:0] rob_name,
  output logic              rob_exc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  ls_state_t         state_q, state_d;
  ls_entry_t         enq, head;
  logic [PW:0]       count;
  logic              full, empty;
  logic              push, pop, issue, fin, trap;
  logic [DATA_W-1:0] eff_addr;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        len_q;
  logic [DATA_W-1:0] wdata_q;

  function automatic logic [DATA_W-1:0] fmt_load(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] d);
    case (op)
      OP_LB:   return {{(DATA_W-8){d[7]}}, d[7:0]};
      OP_LBU:  return {{(DATA_W-8){1'b0}}, d[7:0]};
      OP_LH:   return {{(DATA_W-16){d[15]}}, d[15:0]};
      OP_LHU:  return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // count is a register, so req_ready never depends on the memory side.
  assign req_ready = (count != DEPTH_C);
  assign push      = req_valid & ~full;
  assign eff_addr  = req_base + req_imm;

  assign enq.op    = req_op;
  assign enq.addr  = eff_addr[ADDR_W-1:0];
  assign enq.wdata = req_src;
  assign enq.tag   = req_tag;
  assign enq.name  = req_name;

  ls_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (enq),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, issue/pop decisions.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    fin     = 1'b0;
    trap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !flush) begin
`ifdef LS_MISALIGN_TRAP_EN
          if (op_misaligned(head.op, head.addr[1:0])) begin
            trap = 1'b1;
            pop  = 1'b1;
          end else
`endif
          if (mem_free) begin
            issue   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = mem_done ? ST_IDLE : ST_DRAIN;
        end else if (mem_done) begin
          pop     = 1'b1;
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the issued access so mem_* stay stable while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= 2'b00;
      wdata_q <= '0;
    end else if (issue) begin
      rw_q    <= op_is_store(head.op);
      addr_q  <= head.addr;
      len_q   <= op_len(head.op);
      wdata_q <= head.wdata;
    end
  end

  assign mem_req   = issue;
  assign mem_rw    = issue ? op_is_store(head.op) : rw_q;
  assign mem_addr  = issue ? head.addr            : addr_q;
  assign mem_len   = issue ? op_len(head.op)      : len_q;
  assign mem_wdata = issue ? head.wdata           : wdata_q;

  // ROB completion registers; fin and trap are already masked by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_valid <= 1'b0;
      rob_data  <= '0;
      rob_tag   <= '0;
      rob_name  <= '0;
    end else begin
      rob_valid <= fin | trap;
      if (fin) begin
        rob_tag <= head.tag;
        if (op_is_store(head.op)) begin
          rob_data <= '0;
          rob_name <= '0;
        end else begin
          rob_data <= fmt_load(head.op, mem_rdata);
          rob_name <= head.name;
        end
      end else if (trap) begin
        rob_tag  <= head.tag;
        rob_data <= DATA_W'(head.addr);
        rob_name <= head.name;
      end
    end
  end

`ifdef LS_MISALIGN_TRAP_EN
  // Exception flag travels with each completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rob_exc <= 1'b0;
    else if (fin | trap)  rob_exc <= trap;
  end
`else
  assign rob_exc = 1'b0;
`endif

endmodule
